// File: rtl/vc32_uart_pkg.sv
// rtl/vc32_uart_pkg.sv - shared types and constants for the vc32 UART
//
// Purpose: serialiser state encoding and UART constants shared by the
// transmit FIFO top level and its storage sub-module.
package vc32_uart_pkg;

  // Serialiser states; PARITY is only reachable when UART_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;

  // Simulation bit period: 8000 clocks of 10 ns gives an 80 us bit.
  localparam int UART_DIV_SIM = 8000;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// rtl/uart_tx_fifo_mem.sv - byte FIFO storage with push/pop and occupancy
//
// Purpose: circular byte buffer with wrap-around pointers and an occupancy
// counter. A push while full and a pop while empty are ignored. A push and a
// pop on the same edge leave the count unchanged and advance both pointers.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset (pointers and count cleared)
//   push_i   in   write request
//   wdata_i  in   byte to store
//   pop_i    in   remove head entry
//   rdata_o  out  head entry (valid when count_o != 0)
//   count_o  out  occupancy, 0..DEPTH
//   full_o   out  count_o == DEPTH
module uart_tx_fifo_mem
  import vc32_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [7:0]               wdata_i,
  input  logic                     pop_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // DEPTH is a power of two, so pointer overflow is the wrap-around.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CW'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - vc32 UART transmitter with byte FIFO, 8N1 framing
//
// Purpose: buffers CPU-written bytes and serialises them as idle-high 8N1
// frames (start low, 8 data bits LSB first, stop high). Each bit lasts div
// clocks (0 treated as 1), latched at frame start. Consecutive frames run
// back-to-back with no idle cycle between them.
// Optional macro UART_TX_PARITY_EN adds a parity bit between data and stop
// (even parity, odd when parity_odd=1, sampled at frame start).
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset; abandons any frame
//   wr_valid    in   CPU presents a byte
//   wr_data     in   byte to transmit
//   wr_ready    out  FIFO not full
//   div         in   clocks per bit
//   tx          out  registered serial line
//   busy        out  frame in progress or FIFO non-empty
//   count       out  FIFO occupancy
//   parity_odd  in   (UART_TX_PARITY_EN only) select odd parity
module uart_tx_fifo
  import vc32_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic [DIV_W-1:0]              div,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                          parity_odd
`endif
);

  uart_state_e      state_q;
  logic             tx_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] timer_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  logic             full;
  logic [7:0]       head;
  logic             pop;
  logic             bit_end;
  logic [DIV_W-1:0] div_eff;

  assign div_eff  = (div == '0) ? DIV_W'(1) : div;
  assign bit_end  = (timer_q == '0);
  // A frame is loaded only from IDLE or at the last clock of STOP.
  assign pop      = (count != '0) &&
                    ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  assign wr_ready = !full;
  assign busy     = (state_q != IDLE) || (count != '0);
  assign tx       = tx_q;

  uart_tx_fifo_mem #(
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_valid),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full)
  );

  // tx_q is loaded with the level of the state being entered, so the line
  // changes exactly on the bit boundary edge with no combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
      timer_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q  <= START;
            tx_q     <= 1'b0;
            shift_q  <= head;
            div_q    <= div_eff;
            timer_q  <= div_eff - DIV_W'(1);
`ifdef UART_TX_PARITY_EN
            parity_q <= (^head) ^ parity_odd;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            bit_idx_q <= '0;
            timer_q   <= div_q - DIV_W'(1);
          end else begin
            timer_q <= timer_q - DIV_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            timer_q <= div_q - DIV_W'(1);
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - DIV_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            timer_q <= div_q - DIV_W'(1);
          end else begin
            timer_q <= timer_q - DIV_W'(1);
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            if (pop) begin
              // Next frame starts immediately: no idle cycle between frames.
              state_q  <= START;
              tx_q     <= 1'b0;
              shift_q  <= head;
              div_q    <= div_eff;
              timer_q  <= div_eff - DIV_W'(1);
`ifdef UART_TX_PARITY_EN
              parity_q <= (^head) ^ parity_odd;
`endif
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - DIV_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic [15:0] div;
  logic        tx;
  logic        busy;
  logic [2:0]  count;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd;
`endif

  uart_tx_fifo #(
    .FIFO_DEPTH (4),
    .DIV_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .div        (div),
    .tx         (tx),
    .busy       (busy),
`ifdef UART_TX_PARITY_EN
    .parity_odd (parity_odd),
`endif
    .count      (count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         d;
    logic       par;
  } exp_t;

  exp_t sb[$];
  int   start_q[$];
  int   frames = 0;
  int   aborts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] data, input int d, input logic par);
    exp_t e;
    e.data = data;
    e.d    = d;
    e.par  = par;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int max, output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    c = cyc;
  endtask

  // Line monitor: on a start bit, pops the expected frame and checks every
  // sampled clock of the frame against the expected bit pattern.
  initial begin
    exp_t       e;
    logic [10:0] pat;
    logic [7:0] got;
    int         nb;
    bit         ok;
    bit         ab;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        check("unexpected_start", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          start_q.push_back(cyc);
          pat      = '1;
          pat[0]   = 1'b0;
          pat[8:1] = e.data;
`ifdef UART_TX_PARITY_EN
          pat[9]   = e.par;
          nb       = 11;
`else
          nb       = 10;
`endif
          ok  = 1'b1;
          ab  = 1'b0;
          got = '0;
          for (int b = 0; b < nb && !ab; b++) begin
            for (int k = 0; k < e.d && !ab; k++) begin
              if (b != 0 || k != 0) @(negedge clk);
              if (reset === 1'b1) begin
                ab = 1'b1;
              end else begin
                if (tx !== pat[b]) ok = 1'b0;
                if (k == 0 && b >= 1 && b <= 8) got[b-1] = tx;
              end
            end
          end
          if (ab) begin
            aborts++;
          end else begin
            check("frame_shape", {31'd0, ok}, 32'd1);
            check("frame_byte", {24'd0, got}, {24'd0, e.data});
            frames++;
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int e;
    int s;
    int nf;
    bit low_seen;
    bit exp_ready [6];

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    div      = 16'd4;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

    // Single 0x55 frame, div=4
    nf = start_q.size();
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'h55; push_exp(8'h55, 4, 1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    t = cyc;
    check("wr_count1", {29'd0, count}, 32'd1);
    check("wr_busy", {31'd0, busy}, 32'd1);
    wait_idle(200, e);
    check("f55_started", start_q.size(), nf + 1);
    check("f55_start_lat", start_q[nf], t + 1);
    check("f55_len40", e - start_q[nf], 40);

    // Three back-to-back frames, div=8
    div = 16'd8;
    nf  = start_q.size();
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'h41; push_exp(8'h41, 8, 1'b0);
    @(posedge clk); #1;
    wr_data = 8'h0D; push_exp(8'h0D, 8, 1'b0);
    @(posedge clk); #1;
    wr_data = 8'h0A; push_exp(8'h0A, 8, 1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_idle(600, e);
    check("b2b_frames", start_q.size(), nf + 3);
    check("b2b_gap1", start_q[nf+1] - start_q[nf], 80);
    check("b2b_gap2", start_q[nf+2] - start_q[nf+1], 80);
    check("b2b_total240", e - start_q[nf], 240);

    // Overfill: 6 writes, depth 4, one pop during the burst -> 5 accepted
    div = 16'd16;
    nf  = start_q.size();
    exp_ready = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_data  = 8'h10 + 8'(i);
      check("full_wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready[i]});
      if (exp_ready[i]) push_exp(8'h10 + 8'(i), 16, 1'b0);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    check("full_count4", {29'd0, count}, 32'd4);
    check("full_ready_low", {31'd0, wr_ready}, 32'd0);
    wait_idle(2000, e);
    check("full_frames5", start_q.size(), nf + 5);

    // div=0 acts as 1: 10-clock frame
    div = 16'd0;
    nf  = start_q.size();
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'hA5; push_exp(8'hA5, 1, 1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_idle(100, e);
    check("div0_len10", e - start_q[nf], 10);

    // div change mid-frame only affects the next frame
    div = 16'd4;
    nf  = start_q.size();
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'h3C; push_exp(8'h3C, 4, 1'b0);
    @(posedge clk); #1;
    wr_data = 8'hC3; push_exp(8'hC3, 10, 1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 div = 16'd10;
    wait_idle(400, e);
    check("divchg_first40", start_q[nf+1] - start_q[nf], 40);
    check("divchg_total140", e - start_q[nf], 140);

    // Reset during data bit 3 of 0xF0
    div = 16'd4;
    nf  = start_q.size();
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'hF0; push_exp(8'hF0, 4, 1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    for (int n = 0; n < 20 && start_q.size() == nf; n++) @(negedge clk);
    check("rstmid_started", start_q.size(), nf + 1);
    s = start_q[nf];
    for (int n = 0; n < 40 && cyc < s + 17; n++) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rstmid_tx", {31'd0, tx}, 32'd1);
    check("rstmid_count", {29'd0, count}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    low_seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("rstmid_no_frame", {31'd0, low_seen}, 32'd0);
    check("rstmid_aborts", aborts, 1);
    check("rstmid_sb_empty", sb.size(), 0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones -> parity bit 1
    div        = 16'd4;
    parity_odd = 1'b0;
    nf         = start_q.size();
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'h07; push_exp(8'h07, 4, 1'b1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_idle(200, e);
    check("par_even_len44", e - start_q[nf], 44);

    // Odd parity -> parity bit 0
    parity_odd = 1'b1;
    nf         = start_q.size();
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'h07; push_exp(8'h07, 4, 1'b0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_idle(200, e);
    check("par_odd_len44", e - start_q[nf], 44);
`endif

    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
